morse_encoder: RTL and testbench

Converts ASCII characters into Morse code for the keyer side of the design. It produces two outputs: a timed on/off key signal (`key_out`) and a per-element symbol stream (`morse_signal`) in the team's 2-bit dot/dash/end encoding, so its output can drive the Morse decoder directly in loopback. Characters arrive through a ready/valid handshake, one character at a time, and each is fully sent before the next is accepted.

---
 rtl/morse_encoder.sv | 182 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// ASCII-to-Morse keyer: timed key_out plus a dot/dash/end symbol stream.
// Define MORSE_DIGITS_EN to also encode '0'-'9'; otherwise digits raise char_err.
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic [1:0] morse_signal,
    output logic       busy,
    output logic       char_err
);

    localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DOT_CYC  = CW'(UNIT_CYCLES);
    localparam logic [CW-1:0] DASH_CYC = CW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] CHAR_CYC = CW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] WORD_CYC = CW'(7 * UNIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    elem_reg, elem_next;
    logic [4:0]    pat_reg, pat_next;
    logic          err_reg, err_next;

    logic [7:0] upper_char;
    logic       lk_ok;
    logic [2:0] lk_len;
    logic [4:0] lk_bits;
    logic [4:0] lk_pat;

    // Code table: lk_bits is right-aligned (last element in bit 0), 1 = dash.
    always_comb begin
        upper_char = (char_in >= 8'h61 && char_in <= 8'h7A) ? (char_in - 8'h20) : char_in;
        lk_ok      = 1'b1;
        lk_len     = 3'd0;
        lk_bits    = 5'b00000;
        case (upper_char)
            8'h41: begin lk_len = 3'd2; lk_bits = 5'b00001; end // A .-
            8'h42: begin lk_len = 3'd4; lk_bits = 5'b01000; end // B -...
            8'h43: begin lk_len = 3'd4; lk_bits = 5'b01010; end // C -.-.
            8'h44: begin lk_len = 3'd3; lk_bits = 5'b00100; end // D -..
            8'h45: begin lk_len = 3'd1; lk_bits = 5'b00000; end // E .
            8'h46: begin lk_len = 3'd4; lk_bits = 5'b00010; end // F ..-.
            8'h47: begin lk_len = 3'd3; lk_bits = 5'b00110; end // G --.
            8'h48: begin lk_len = 3'd4; lk_bits = 5'b00000; end // H ....
            8'h49: begin lk_len = 3'd2; lk_bits = 5'b00000; end // I ..
            8'h4A: begin lk_len = 3'd4; lk_bits = 5'b00111; end // J .---
            8'h4B: begin lk_len = 3'd3; lk_bits = 5'b00101; end // K -.-
            8'h4C: begin lk_len = 3'd4; lk_bits = 5'b00100; end // L .-..
            8'h4D: begin lk_len = 3'd2; lk_bits = 5'b00011; end // M --
            8'h4E: begin lk_len = 3'd2; lk_bits = 5'b00010; end // N -.
            8'h4F: begin lk_len = 3'd3; lk_bits = 5'b00111; end // O ---
            8'h50: begin lk_len = 3'd4; lk_bits = 5'b00110; end // P .--.
            8'h51: begin lk_len = 3'd4; lk_bits = 5'b01101; end // Q --.-
            8'h52: begin lk_len = 3'd3; lk_bits = 5'b00010; end // R .-.
            8'h53: begin lk_len = 3'd3; lk_bits = 5'b00000; end // S ...
            8'h54: begin lk_len = 3'd1; lk_bits = 5'b00001; end // T -
            8'h55: begin lk_len = 3'd3; lk_bits = 5'b00001; end // U ..-
            8'h56: begin lk_len = 3'd4; lk_bits = 5'b00001; end // V ...-
            8'h57: begin lk_len = 3'd3; lk_bits = 5'b00011; end // W .--
            8'h58: begin lk_len = 3'd4; lk_bits = 5'b01001; end // X -..-
            8'h59: begin lk_len = 3'd4; lk_bits = 5'b01011; end // Y -.--
            8'h5A: begin lk_len = 3'd4; lk_bits = 5'b01100; end // Z --..
`ifdef MORSE_DIGITS_EN
            8'h30: begin lk_len = 3'd5; lk_bits = 5'b11111; end
            8'h31: begin lk_len = 3'd5; lk_bits = 5'b01111; end
            8'h32: begin lk_len = 3'd5; lk_bits = 5'b00111; end
            8'h33: begin lk_len = 3'd5; lk_bits = 5'b00011; end
            8'h34: begin lk_len = 3'd5; lk_bits = 5'b00001; end
            8'h35: begin lk_len = 3'd5; lk_bits = 5'b00000; end
            8'h36: begin lk_len = 3'd5; lk_bits = 5'b10000; end
            8'h37: begin lk_len = 3'd5; lk_bits = 5'b11000; end
            8'h38: begin lk_len = 3'd5; lk_bits = 5'b11100; end
            8'h39: begin lk_len = 3'd5; lk_bits = 5'b11110; end
`endif
            default: lk_ok = 1'b0;
        endcase
        // Left-align so the element being sent is always pat_reg[4].
        lk_pat = lk_bits << (3'd5 - lk_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            elem_reg  <= 3'd0;
            pat_reg   <= 5'b00000;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            elem_reg  <= elem_next;
            pat_reg   <= pat_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        elem_next  = elem_reg;
        pat_next   = pat_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (char_valid) begin
                    if (lk_ok) begin
                        state_next = MARK;
                        pat_next   = lk_pat;
                        elem_next  = lk_len;
                        cnt_next   = lk_pat[4] ? DASH_CYC : DOT_CYC;
                    end else if (char_in == 8'h20) begin
                        state_next = WORD_GAP;
                        cnt_next   = WORD_CYC;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt_reg == ONE) begin
                    if (elem_reg > 3'd1) begin
                        state_next = ELEM_GAP;
                        cnt_next   = DOT_CYC;
                        elem_next  = elem_reg - 3'd1;
                        pat_next   = {pat_reg[3:0], 1'b0};
                    end else begin
                        state_next = CHAR_GAP;
                        cnt_next   = CHAR_CYC;
                        elem_next  = 3'd0;
                    end
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            ELEM_GAP: begin
                if (cnt_reg == ONE) begin
                    state_next = MARK;
                    cnt_next   = pat_reg[4] ? DASH_CYC : DOT_CYC;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_reg == ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from registered state so an async reset clears them at once.
    always_comb begin
        busy         = (state_reg != IDLE);
        char_ready   = !busy;
        key_out      = (state_reg == MARK);
        char_err     = err_reg;
        morse_signal = 2'b11;
        if (state_reg == MARK && cnt_reg == (pat_reg[4] ? DASH_CYC : DOT_CYC))
            morse_signal = pat_reg[4] ? 2'b10 : 2'b01;
        else if (state_reg == CHAR_GAP && cnt_reg == CHAR_CYC)
            morse_signal = 2'b00;
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder (UNIT_CYCLES=2): a per-cycle expectation
// queue is filled from a bench-side code table and drained against the outputs.
module tb_morse_encoder;

    localparam int U = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       key_out;
    logic [1:0] morse_signal;
    logic       busy;
    logic       char_err;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk          (clk),
        .rst          (rst),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .key_out      (key_out),
        .morse_signal (morse_signal),
        .busy         (busy),
        .char_err     (char_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       key;
        logic [1:0] sym;
        logic       ready;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic pending_err = 1'b0;
    int   cyc = 0;

    string letter_codes[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                                "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                                "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                                "-.--", "--.."};
    string digit_codes[10] = '{"-----", ".----", "..---", "...--", "....-",
                               ".....", "-....", "--...", "---..", "----."};

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic push(input logic key, input logic [1:0] sym, input logic ready, input logic err);
        exp_t e;
        e.key = key; e.sym = sym; e.ready = ready; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".key_out"}, {1'b0, key_out}, {1'b0, e.key});
        chk({tag, ".morse_signal"}, morse_signal, e.sym);
        chk({tag, ".char_ready"}, {1'b0, char_ready}, {1'b0, e.ready});
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, !e.ready});
        chk({tag, ".char_err"}, {1'b0, char_err}, {1'b0, e.err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u >= 8'h41 && u <= 8'h5A) return letter_codes[u - 8'h41];
`ifdef MORSE_DIGITS_EN
        if (u >= 8'h30 && u <= 8'h39) return digit_codes[u - 8'h30];
`endif
        return "";
    endfunction

    // Called in the cycle where the character is presented (cycle 0).
    // Returns after checking the last busy cycle, or cycle 1 for a rejected char.
    task automatic send(input logic [7:0] c, input bit hold, input string tag);
        string s;
        int    n;
        cyc = 0;
        push(1'b0, 2'b11, 1'b1, pending_err);
        pending_err = 1'b0;
        s = code_of(c);
        if (c == 8'h20) begin
            for (int j = 0; j < 7 * U; j++) push(1'b0, 2'b11, 1'b0, 1'b0);
        end else if (s.len() > 0) begin
            for (int k = 0; k < s.len(); k++) begin
                logic dash;
                dash = (s[k] == 8'h2D);
                for (int j = 0; j < (dash ? 3 * U : U); j++)
                    push(1'b1, (j == 0) ? (dash ? 2'b10 : 2'b01) : 2'b11, 1'b0, 1'b0);
                if (k < s.len() - 1)
                    for (int j = 0; j < U; j++) push(1'b0, 2'b11, 1'b0, 1'b0);
            end
            for (int j = 0; j < 3 * U; j++) push(1'b0, (j == 0) ? 2'b00 : 2'b11, 1'b0, 1'b0);
        end
        char_in = c;
        char_valid = 1'b1;
        check_now(tag);
        if (c != 8'h20 && s.len() == 0) begin
            tick();
            char_valid = 1'b0;
            pending_err = 1'b1;
            $display("txn %s char=0x%02h rejected", tag, c);
            return;
        end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0 && !hold) char_valid = 1'b0;
            check_now(tag);
        end
        char_valid = 1'b0;
        $display("txn %s char=0x%02h busy_cycles=%0d", tag, c, n);
    endtask

    initial begin
        #1;
        chk("reset.key_out", {1'b0, key_out}, 2'b00);
        chk("reset.morse_signal", morse_signal, 2'b11);
        chk("reset.char_ready", {1'b0, char_ready}, 2'b01);
        chk("reset.busy", {1'b0, busy}, 2'b00);
        chk("reset.char_err", {1'b0, char_err}, 2'b00);
        #20;
        rst = 1'b0;
        tick();

        send(8'h45, 1'b0, "E");
        tick();
        send(8'h41, 1'b0, "A");
        tick();
        send(8'h71, 1'b1, "q_hold");
        tick();
        send(8'h23, 1'b0, "hash");
        send(8'h45, 1'b0, "E_after_err");
        tick();
        send(8'h35, 1'b0, "digit5");
        send(8'h20, 1'b0, "space");
        tick();
        send(8'h54, 1'b0, "T_b2b");
        tick();
        send(8'h65, 1'b0, "e_b2b");
        tick();

        // Reset pulse in the middle of the dash of 'T'.
        cyc = 0;
        push(1'b0, 2'b11, 1'b1, pending_err);
        pending_err = 1'b0;
        char_in = 8'h54;
        char_valid = 1'b1;
        check_now("T_rst");
        tick();
        char_valid = 1'b0;
        chk("T_rst.first_sym", morse_signal, 2'b10);
        tick();
        tick();
        chk("T_rst.key_mid", {1'b0, key_out}, 2'b01);
        rst = 1'b1;
        #1;
        chk("T_rst.key_out", {1'b0, key_out}, 2'b00);
        chk("T_rst.morse_signal", morse_signal, 2'b11);
        chk("T_rst.char_ready", {1'b0, char_ready}, 2'b01);
        #1;
        rst = 1'b0;
        $display("txn T_rst reset pulsed at cycle %0d", cyc);
        tick();
        push(1'b0, 2'b11, 1'b1, 1'b0);
        check_now("after_rst_idle");
        tick();
        send(8'h45, 1'b0, "E_after_rst");
        tick();
        push(1'b0, 2'b11, 1'b1, pending_err);
        check_now("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
